// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//
// Shared constants and helpers for the pushbutton/switch debounce bank.
//   - Default timing constants for the 65 MHz board clock.
//   - Channel index constants naming the board pushbuttons, so consumers
//     (game_fsm, display) can pick bits out of the bank outputs by name.
//   - Repeat-limit selector type used by the per-channel repeat engine.
//   - max_int helper used for sizing the repeat counter.
// ---------------------------------------------------------------------------
package debounce_pkg;

    // ~15.4 ms of stable input at 65 MHz before the clean level moves.
    localparam int DB_STABLE_65MHZ        = 1000000;
    // 0.5 s hold before the first auto-repeat press.
    localparam int DB_REPEAT_DELAY_65MHZ  = 32500000;
    // 0.1 s between subsequent auto-repeat presses.
    localparam int DB_REPEAT_PERIOD_65MHZ = 6500000;

    // Bit positions of the board pushbuttons within the bank vectors.
    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    // Default bank width: one channel per board pushbutton.
    localparam int DB_N_CH_BOARD = BTN_D + 1;

    // Which interval the repeat counter is currently timing.
    typedef enum logic {
        LIM_DELAY  = 1'b0,
        LIM_PERIOD = 1'b1
    } rep_limit_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// One debounced input: synchronizer chain, stability counter, registered
// clean level with rise/fall pulses, and a hold-to-repeat press generator.
//
// Ports:
//   clock_in    in   system clock
//   reset_in_n  in   asynchronous active-low reset, clears all state
//   noisy_in    in   raw asynchronous level from the board
//   repeat_en   in   enables auto-repeat presses while the level is held high
//   clean_out   out  debounced level
//   rise_out    out  one-cycle pulse on clean_out 0->1
//   fall_out    out  one-cycle pulse on clean_out 1->0
//   press_out   out  one-cycle pulse on every rise and every repeat
//
// The clean level follows the synchronized input only after it has matched
// the current candidate for STABLE_COUNT consecutive edges; any change of
// the synchronized input restarts that wait.
// ---------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT  = DB_STABLE_65MHZ,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_65MHZ,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_65MHZ
) (
    input  logic clock_in,
    input  logic reset_in_n,
    input  logic noisy_in,
    input  logic repeat_en,
    output logic clean_out,
    output logic rise_out,
    output logic fall_out,
    output logic press_out
);

    localparam int CNT_W = $clog2(STABLE_COUNT);
    localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(STABLE_COUNT - 1);
    localparam logic [REP_W-1:0] DELAY_LAST   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST  = REP_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_s;

    logic                   cand_p1;
    logic [CNT_W-1:0]       cnt_p1;

    logic [REP_W-1:0]       rep_cnt_p2;
    rep_limit_e             rep_lim_p2;

    logic                   stable_done;
    logic                   rise_now;
    logic                   fall_now;
    logic                   rep_active;
    logic [REP_W-1:0]       rep_last;
    logic                   rep_hit;
    logic                   rep_due;

    assign sync_s = sync_p0[SYNC_STAGES-1];

    always_comb begin
        // Candidate has held long enough; clean_out takes its value this edge.
        stable_done = (sync_s == cand_p1) && (cnt_p1 == CNT_LAST);
        rise_now    = stable_done &&  cand_p1 && !clean_out;
        fall_now    = stable_done && !cand_p1 &&  clean_out;

        rep_active  = clean_out && repeat_en;
        rep_last    = (rep_lim_p2 == LIM_DELAY) ? DELAY_LAST : PERIOD_LAST;
        rep_hit     = rep_active && (rep_cnt_p2 == rep_last);
        // A release landing on the same edge as a due repeat wins.
        rep_due     = rep_hit && !fall_now;
    end

    // ---- p0: input synchronizer --------------------------------------------
    // ---- p1: stability counter and clean level ------------------------------
    always_ff @(posedge clock_in or negedge reset_in_n) begin
        if (!reset_in_n) begin
            sync_p0   <= '0;
            cand_p1   <= 1'b0;
            cnt_p1    <= '0;
            clean_out <= 1'b0;
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], noisy_in};

            if (sync_s != cand_p1) begin
                cand_p1 <= sync_s;
                cnt_p1  <= '0;
            end else if (cnt_p1 == CNT_LAST) begin
                // Counter saturates here; the clean level keeps tracking cand.
                clean_out <= cand_p1;
            end else begin
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end

            rise_out <= rise_now;
            fall_out <= fall_now;
        end
    end

    // ---- p2: repeat engine and press stream ---------------------------------
    always_ff @(posedge clock_in or negedge reset_in_n) begin
        if (!reset_in_n) begin
            rep_cnt_p2 <= '0;
            rep_lim_p2 <= LIM_DELAY;
            press_out  <= 1'b0;
        end else begin
            if (rise_now || !rep_active || fall_now) begin
                // Idle, fresh press, or release: re-arm for the long first wait.
                rep_cnt_p2 <= '0;
                rep_lim_p2 <= LIM_DELAY;
            end else if (rep_hit) begin
                rep_cnt_p2 <= '0;
                rep_lim_p2 <= LIM_PERIOD;
            end else begin
                rep_cnt_p2 <= rep_cnt_p2 + REP_W'(1);
            end

            press_out <= rise_now || rep_due;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//
// Multi-channel debouncer covering all board pushbuttons and switches.
// Each bit of the vectors is an independent debounce_channel; nothing is
// shared between channels.
//
// Ports:
//   clock_in    in   system clock (65 MHz on the board)
//   reset_in_n  in   asynchronous active-low reset
//   noisy_in    in   [N_CH] raw asynchronous button/switch levels
//   repeat_en   in   [N_CH] per-channel auto-repeat enable
//   clean_out   out  [N_CH] debounced levels
//   rise_out    out  [N_CH] one-cycle pulse on each clean 0->1
//   fall_out    out  [N_CH] one-cycle pulse on each clean 1->0
//   press_out   out  [N_CH] one-cycle pulse per rise or auto-repeat
// ---------------------------------------------------------------------------
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = DB_N_CH_BOARD,
    parameter int STABLE_COUNT  = DB_STABLE_65MHZ,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_65MHZ,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_65MHZ
) (
    input  logic            clock_in,
    input  logic            reset_in_n,
    input  logic [N_CH-1:0] noisy_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_out,
    output logic [N_CH-1:0] fall_out,
    output logic [N_CH-1:0] press_out
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .STABLE_COUNT  (STABLE_COUNT),
            .SYNC_STAGES   (SYNC_STAGES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clock_in   (clock_in),
            .reset_in_n (reset_in_n),
            .noisy_in   (noisy_in[ch]),
            .repeat_en  (repeat_en[ch]),
            .clean_out  (clean_out[ch]),
            .rise_out   (rise_out[ch]),
            .fall_out   (fall_out[ch]),
            .press_out  (press_out[ch])
        );
    end

endmodule
